ahb_lite_master: RTL and testbench
==================================

// Module: ahb_lite_master
// PURPOSE
//   Single-initiator AHB-Lite master port: turns a simple command/response interface into
//   pipelined AHB-Lite SINGLE transfers. Drives the address/control/HWDATA side and samples
//   HREADY/HRESP/HRDATA, so the on-chip slaves (RAM, peripherals) can be driven by a
//   non-CPU agent (loader, DMA, debug bridge). Overlaps address and data phases: 1 transfer/cycle.
// PARAMETERS
//   HPROT_VAL  4'b0011  constant driven on HPROT (non-cacheable, privileged data access)
// PORTS
//   HCLK       in   1   bus clock; all logic on rising edge
//   HRESET     in   1   asynchronous, active-high reset
//   cmd_valid  in   1   command present
//   cmd_ready  out  1   command accepted at edge where cmd_valid&&cmd_ready
//   cmd_write  in   1   1=write, 0=read
//   cmd_addr   in   32  byte address; caller guarantees natural alignment for cmd_size
//   cmd_size   in   2   0=byte, 1=halfword, 2=word (3 illegal; treated as word)
//   cmd_wdata  in   32  write data, right-justified (byte in [7:0], halfword in [15:0])
//   rsp_valid  out  1   one-cycle pulse per completed transfer, strictly in command order
//   rsp_rdata  out  32  read data, right-justified, zero-extended; 0 for writes
//   rsp_error  out  1   1 when the transfer ended with HRESP=ERROR
//   HADDR      out  32  AHB address       HTRANS  out 2  IDLE(00)/NONSEQ(10) only
//   HWRITE     out  1   AHB direction     HSIZE   out 3  {1'b0,size}
//   HBURST     out  3   constant 3'b000   HPROT   out 4  HPROT_VAL   HMASTLOCK out 1  constant 0
//   HWDATA     out  32  write data, lane-replicated
//   HREADY     in   1   bus ready (interconnect-muxed HREADYOUT)
//   HRESP      in   1   0=OKAY, 1=ERROR
//   HRDATA     in   32  read data
// BEHAVIOUR
//   Reset: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0,
//     rsp_error=0. Async reset mid-transfer idles the bus immediately; in-flight cmds dropped, no rsp.
//   All bus outputs and rsp_* are registered. cmd_ready = HREADY (combinational, from bus).
//   Address stage (AP regs): at each edge with HREADY=1, AP loads cmd (HTRANS=NONSEQ) if
//     cmd_valid, else HTRANS=IDLE. With HREADY=0 all AP outputs hold stable (protocol rule).
//   Data stage (DP regs: active, write, size, addr[1:0]): at each edge with HREADY=1 DP loads
//     from AP (active=HTRANS==NONSEQ). HWDATA loads with AP's write data on the same edge
//     and holds while HREADY=0.
//   HWDATA replication: byte -> {4{d[7:0]}}, halfword -> {2{d[15:0]}}, word -> d.
//   Completion: edge with DP.active && HREADY=1 -> next cycle rsp_valid=1, rsp_error=HRESP,
//     rsp_rdata = read ? (HRDATA >> 8*addr[1:0]) masked to size : 0. Otherwise rsp_valid=0.
//   Latency (zero-wait): cmd accepted edge E0 -> NONSEQ on bus E0..E1 -> data phase E1..E2
//     -> rsp_valid high in cycle after E2. Each HREADY-low cycle in data phase adds 1.
//   Error: on first ERROR cycle (HRESP=1,HREADY=0) pending AP transfer is NOT cancelled; it
//     holds and proceeds normally. Erroring transfer reports rsp_error=1, rsp_rdata=0.
//   Back-to-back: new cmd may be accepted every HREADY-high edge; responses in order, no gaps
//     beyond those caused by wait states or cmd_valid low.
//   No rsp backpressure: consumer must accept every rsp_valid pulse.
// TESTING (bench: this master + ahb RAM slave + wait/error-injecting dummy slave)
//   1 Assert HRESET mid-burst -> outputs at reset values same cycle; no rsp_valid after release.
//   2 Write word 0xDEADBEEF @0x100, then read @0x100 -> rsp_rdata=0xDEADBEEF, rsp_error=0,
//     rsp_valid exactly 2 cycles after each accept edge.
//   3 Write byte 0xA5 @0x103 -> HSIZE=0, HWDATA=0xA5A5A5A5; read byte @0x103 -> rsp_rdata=0x000000A5;
//     read word @0x100 -> 0xA5ADBEEF.
//   4 Four cmds with cmd_valid held, HREADY=1 -> NONSEQ on 4 consecutive cycles, 4 consecutive
//     rsp_valid pulses in issue order.
//   5 Dummy slave inserts 2 wait states on a read -> cmd_ready=0 and HADDR/HTRANS/HWDATA
//     stable for 2 cycles, rsp_valid delayed by 2.
//   6 Dummy slave returns 2-cycle ERROR on a write followed by a read -> rsp_error=1 then
//     rsp_error=0 with correct read data.

Source files
------------

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-initiator master: maps a command/response interface onto pipelined
// SINGLE transfers with overlapped address and data phases (one transfer per cycle).
module ahb_lite_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  // command side
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  // response side
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  // AHB-Lite bus
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_NONSEQ = 2'b10
  } trans_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // address stage
  trans_e      ap_trans;
  size_e       ap_size;
  logic [31:0] ap_wdata;

  // data stage
  logic        dp_active;
  logic        dp_write;
  size_e       dp_size;
  logic [1:0]  dp_lane;

  size_e       cmd_size_eff;
  logic [31:0] wdata_lanes;
  logic [31:0] rdata_shifted;
  logic [31:0] rdata_ext;

  // NOTE: every always_comb output gets a default on the first line, so no path can leave it unassigned and infer a latch.
  always_comb begin
    cmd_size_eff = SZ_WORD;
    if (cmd_size != 2'd3) cmd_size_eff = size_e'(cmd_size);

    wdata_lanes = ap_wdata;
    case (ap_size)
      SZ_BYTE: wdata_lanes = {4{ap_wdata[7:0]}};
      SZ_HALF: wdata_lanes = {2{ap_wdata[15:0]}};
      default: wdata_lanes = ap_wdata;
    endcase

    rdata_shifted = HRDATA >> {dp_lane, 3'b000};
    rdata_ext     = rdata_shifted;
    case (dp_size)
      SZ_BYTE: rdata_ext = {24'h0, rdata_shifted[7:0]};
      SZ_HALF: rdata_ext = {16'h0, rdata_shifted[15:0]};
      default: rdata_ext = rdata_shifted;
    endcase
  end

  assign cmd_ready = HREADY;
  assign HTRANS    = ap_trans;
  assign HSIZE     = {1'b0, ap_size};
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  // NOTE: registers use non-blocking assignments so every stage samples the pre-edge value of the stage before it.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ap_trans <= TRANS_IDLE;
      HADDR    <= '0;
      HWRITE   <= 1'b0;
      ap_size  <= SZ_BYTE;
      ap_wdata <= '0;
    end else if (HREADY) begin
      if (cmd_valid) begin
        ap_trans <= TRANS_NONSEQ;
        HADDR    <= cmd_addr;
        HWRITE   <= cmd_write;
        ap_size  <= cmd_size_eff;
        ap_wdata <= cmd_wdata;
      end else begin
        ap_trans <= TRANS_IDLE;
      end
    end
  end

  // Data stage and HWDATA advance together; both freeze while the slave stretches the data phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_active <= 1'b0;
      dp_write  <= 1'b0;
      dp_size   <= SZ_BYTE;
      dp_lane   <= 2'b00;
      HWDATA    <= '0;
    end else if (HREADY) begin
      dp_active <= (ap_trans == TRANS_NONSEQ);
      dp_write  <= HWRITE;
      dp_size   <= ap_size;
      dp_lane   <= HADDR[1:0];
      HWDATA    <= wdata_lanes;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= dp_active && HREADY;
      if (dp_active && HREADY) begin
        rsp_error <= HRESP;
        rsp_rdata <= (!dp_write && !HRESP) ? rdata_ext : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: RAM slave with wait/error injection, reference memory model,
// and a response scoreboard popped by an independent monitor.
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [1:0]  cmd_size = '0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  ahb_lite_master #(.HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  hsize;
    logic [31:0] wrep;
    int          waits;
    logic        err;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    int          acc_low;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lows = 0;
  int rsp_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // edge counter and count of edges at which the bus was stalled
  always @(posedge HCLK) begin
    cyc <= cyc + 1;
    if (!HREADY) lows <= lows + 1;
  end

  // bus values sampled mid-cycle; the slave consumes them at the following edge
  logic        n_hready = 1'b1;
  logic [1:0]  n_htrans = '0;
  logic [31:0] n_haddr = '0;
  logic        n_hwrite = 1'b0;
  logic [2:0]  n_hsize = '0;
  logic [31:0] n_hwdata = '0;
  logic        hold_armed = 1'b0;

  // slave
  logic        s_active = 1'b0;
  logic        s_write = 1'b0;
  logic        s_err = 1'b0;
  logic [31:0] s_addr = '0;
  logic [1:0]  s_size = '0;
  logic [31:0] s_wrep = '0;
  int          s_cnt = 0;

  assign HREADY = !s_active || (s_cnt == 0);
  assign HRESP  = s_active && s_err;
  assign HRDATA = (s_active && !s_write) ? mem[s_addr[9:2]] : 32'h0;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      s_active <= 1'b0;
      s_err    <= 1'b0;
      s_write  <= 1'b0;
      s_cnt    <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (n_hready) begin
      if (s_active && s_write && !s_err) begin
        check("hwdata", n_hwdata, s_wrep);
        case (s_size)
          2'd0:    mem[s_addr[9:2]][8*s_addr[1:0] +: 8]  <= n_hwdata[8*s_addr[1:0] +: 8];
          2'd1:    mem[s_addr[9:2]][16*s_addr[1] +: 16]  <= n_hwdata[16*s_addr[1] +: 16];
          default: mem[s_addr[9:2]] <= n_hwdata;
        endcase
      end
      if (n_htrans == 2'b10) begin
        if (plan_q.size() == 0) begin
          check("unplanned_nonseq", 1, 0);
          s_active <= 1'b0;
        end else begin
          check("haddr", n_haddr, plan_q[0].addr);
          check("hwrite", n_hwrite, plan_q[0].write);
          check("hsize", n_hsize, plan_q[0].hsize);
          s_active <= 1'b1;
          s_write  <= plan_q[0].write;
          s_addr   <= plan_q[0].addr;
          s_size   <= plan_q[0].hsize[1:0];
          s_wrep   <= plan_q[0].wrep;
          s_err    <= plan_q[0].err;
          s_cnt    <= plan_q[0].err ? 1 : plan_q[0].waits;
          void'(plan_q.pop_front());
        end
      end else begin
        check("htrans_idle", n_htrans, 2'b00);
        s_active <= 1'b0;
      end
    end else if (s_cnt > 0) begin
      s_cnt <= s_cnt - 1;
    end
  end

  // monitor: bus stability under stalls, cmd_ready, and scoreboard of responses
  always @(negedge HCLK) begin
    if (!HRESET) begin
      check("cmd_ready", cmd_ready, HREADY);
      if (hold_armed && !n_hready)
        check("hold_bus", {HADDR, HTRANS, HWRITE, HSIZE, HWDATA},
              {n_haddr, n_htrans, n_hwrite, n_hsize, n_hwdata});
      if (rsp_valid) begin
        rsp_seen <= rsp_seen + 1;
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
          check("rsp_error", rsp_error, exp_q[0].err);
          check("rsp_latency", cyc - exp_q[0].acc_cyc - (lows - exp_q[0].acc_low), 2);
          void'(exp_q.pop_front());
        end
      end
    end
    hold_armed <= !HRESET;
    n_hready   <= HREADY;
    n_htrans   <= HTRANS;
    n_haddr    <= HADDR;
    n_hwrite   <= HWRITE;
    n_hsize    <= HSIZE;
    n_hwdata   <= HWDATA;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  // Present one command (called just after a falling edge), wait for acceptance, and
  // record what the slave should see and what the response must be.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wd, input int waits, input bit err);
    logic [1:0]  eff;
    logic [31:0] rep;
    logic [31:0] rd;
    int          nbytes;
    int          idx;
    int          lo;
    int          guard;
    plan_t       p;
    exp_t        e;
    eff    = (size == 2'd3) ? 2'd2 : size;
    nbytes = 1 << eff;
    idx    = int'(addr[9:2]);
    lo     = int'(addr[1:0]);
    rep    = '0;
    for (int b = 0; b < 4; b++) rep[8*b +: 8] = wd[8*(b % nbytes) +: 8];

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wd;
    guard = 0;
    while (!HREADY && guard < 50) begin
      @(negedge HCLK);
      guard++;
    end
    if (!HREADY) begin
      check("accept_timeout", 1, 0);
      cmd_valid = 1'b0;
      return;
    end

    rd = '0;
    if (!wr && !err)
      for (int b = 0; b < nbytes; b++) rd[8*b +: 8] = ref_mem[idx][8*(lo+b) +: 8];
    if (wr && !err)
      for (int b = 0; b < nbytes; b++) ref_mem[idx][8*(lo+b) +: 8] = wd[8*b +: 8];

    p = '{addr, wr, {1'b0, eff}, rep, waits, err};
    plan_q.push_back(p);
    e = '{rd, err, cyc + 1, lows};
    exp_q.push_back(e);
    @(negedge HCLK);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int          saved;
    int          guard;
    logic [1:0]  sz;
    logic [31:0] a;
    bit          wr;
    bit          er;
    int          wt;

    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    repeat (2) @(negedge HCLK);
    check("reset_outputs", {HTRANS, HADDR, HWRITE, HSIZE, HWDATA, rsp_valid, rsp_rdata, rsp_error}, '0);
    HRESET = 1'b0;
    @(negedge HCLK);

    // reset in the middle of a burst of reads
    issue(0, 32'h10, 2'd2, 0, 0, 0);
    issue(0, 32'h14, 2'd2, 0, 0, 0);
    issue(0, 32'h18, 2'd1, 0, 0, 0);
    #2 HRESET = 1'b1;
    #1 check("reset_midburst", {HTRANS, HADDR, HWRITE, HSIZE, HWDATA, rsp_valid}, '0);
    exp_q.delete();
    plan_q.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    idle(2);
    HRESET = 1'b0;
    saved = rsp_seen;
    idle(6);
    check("no_rsp_after_reset", rsp_seen, saved);

    // word write then read back
    issue(1, 32'h100, 2'd2, 32'hDEADBEEF, 0, 0);
    idle(3);
    issue(0, 32'h100, 2'd2, 0, 0, 0);
    idle(3);

    // byte lane write/read and merged word read
    issue(1, 32'h103, 2'd0, 32'h000000A5, 0, 0);
    issue(0, 32'h103, 2'd0, 0, 0, 0);
    issue(0, 32'h100, 2'd2, 0, 0, 0);
    idle(3);

    // four back-to-back commands
    issue(1, 32'h200, 2'd2, 32'h11223344, 0, 0);
    issue(1, 32'h206, 2'd1, 32'hFFFF5566, 0, 0);
    issue(0, 32'h200, 2'd1, 0, 0, 0);
    issue(0, 32'h204, 2'd2, 0, 0, 0);
    idle(3);

    // two wait states on a read with a command queued behind it
    issue(1, 32'h300, 2'd2, 32'hCAFEF00D, 0, 0);
    issue(0, 32'h300, 2'd2, 0, 2, 0);
    issue(0, 32'h302, 2'd1, 0, 0, 0);
    idle(4);

    // errored write followed by a read of the same location
    issue(1, 32'h100, 2'd2, 32'h12345678, 0, 1);
    issue(0, 32'h100, 2'd2, 0, 0, 0);
    idle(3);

    // randomized traffic
    repeat (300) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 1023));
      case (sz)
        2'd0:    a = a;
        2'd1:    a = a & ~32'h1;
        default: a = a & ~32'h3;
      endcase
      wr = 1'($urandom_range(0, 1));
      er = ($urandom_range(0, 9) == 0);
      wt = (!er && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      issue(wr, a, sz, $urandom, wt, er);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge HCLK);
      guard++;
    end
    if (exp_q.size() != 0) check("rsp_drain", exp_q.size(), 0);
    check("plan_drain", plan_q.size(), 0);
    check("const_ctrl", {HBURST, HPROT, HMASTLOCK}, {3'b000, 4'b0011, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
